// File: rtl/hazard_forward_ctrl.sv
// ID-stage hazard and forwarding scheduler for the 16-bit 5-stage pipeline.
// Shadows the EX/MEM/WB destinations, selects operand sources, stalls on load-use.
module hazard_forward_ctrl #(
  parameter int REG_BITS  = 3,
  parameter bit ZERO_HARD = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                id_useA,
  input  logic                id_useB,
  input  logic [REG_BITS-1:0] id_RA,
  input  logic [REG_BITS-1:0] id_RB,
  input  logic                id_RegWr,
  input  logic                id_MemRd,
  input  logic [REG_BITS-1:0] id_Rd,
  input  logic                flush,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                stall,
  output logic                bubble,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  typedef struct packed {
    logic                v;
    logic                reg_wr;
    logic                mem_rd;
    logic [REG_BITS-1:0] rd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SRC_REGFILE = 2'd0,
    SRC_EX      = 2'd1,
    SRC_MEM     = 2'd2,
    SRC_WB      = 2'd3
  } fwd_src_e;

  sb_entry_t ex_q, mem_q, wb_q;

  logic ex_a, mem_a, wb_a;
  logic ex_b, mem_b, wb_b;
  logic stall_int, bubble_int;
  fwd_src_e fwd_a, fwd_b;

  function automatic logic producer_match(input sb_entry_t s, input logic use_x,
                                          input logic [REG_BITS-1:0] rx, input logic valid);
    return s.v & s.reg_wr & use_x & valid & (s.rd == rx) & !(ZERO_HARD && (rx == '0));
  endfunction

  // Nearest producer wins; a load still in EX has no result to forward yet.
  function automatic fwd_src_e select_src(input logic ex_m, input logic ex_load,
                                          input logic mem_m, input logic wb_m);
    if (ex_m && !ex_load) return SRC_EX;
    else if (mem_m)       return SRC_MEM;
    else if (wb_m)        return SRC_WB;
    else                  return SRC_REGFILE;
  endfunction

  always_comb begin
    ex_a  = producer_match(ex_q,  id_useA, id_RA, id_valid);
    mem_a = producer_match(mem_q, id_useA, id_RA, id_valid);
    wb_a  = producer_match(wb_q,  id_useA, id_RA, id_valid);
    ex_b  = producer_match(ex_q,  id_useB, id_RB, id_valid);
    mem_b = producer_match(mem_q, id_useB, id_RB, id_valid);
    wb_b  = producer_match(wb_q,  id_useB, id_RB, id_valid);

    stall_int  = !flush & (ex_a | ex_b) & ex_q.mem_rd;
    bubble_int = stall_int | flush | !id_valid;

    fwd_a = SRC_REGFILE;
    fwd_b = SRC_REGFILE;
    if (!stall_int) begin
      fwd_a = select_src(ex_a, ex_q.mem_rd, mem_a, wb_a);
      fwd_b = select_src(ex_b, ex_q.mem_rd, mem_b, wb_b);
    end
  end

  // NOTE: reset is asynchronous, so the combinational outputs are gated by it too;
  // otherwise bubble would follow !id_valid while the block is held in reset.
  always_comb begin
    ForwardA = 2'd0;
    ForwardB = 2'd0;
    stall    = 1'b0;
    bubble   = 1'b0;
    if (!reset) begin
      ForwardA = fwd_a;
      ForwardB = fwd_b;
      stall    = stall_int;
      bubble   = bubble_int;
    end
  end

  // NOTE: all state uses non-blocking assignments so the WB<=MEM<=EX shift reads
  // the pre-edge values of every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble_int) ex_q <= '0;
      else            ex_q <= '{v: id_valid, reg_wr: id_RegWr, mem_rd: id_MemRd, rd: id_Rd};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_int && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_W'(1);
      if (bubble_int && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
